// File: rtl/ofm_requant_writer_if.sv
// rtl/ofm_requant_writer_if.sv - accumulator input, config and RAM write bus of ofm_requant_writer
interface ofm_requant_writer_if #(
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 32
);
  logic                     in_wr_en;
  logic [LANES*ACC_W-1:0]   in_data;
  logic [ADDR_W-1:0]        in_addr;
  logic [ADDR_W-1:0]        cfg_base_addr;
  logic [4:0]               cfg_shift;
  logic                     cfg_relu_en;
  logic [15:0]              cfg_num_words;
  logic                     ram_ready;
  logic                     ram_wr_en;
  logic [ADDR_W-1:0]        ram_addr;
  logic [LANES*8-1:0]       ram_wr_data;
  logic                     layer_done;
  logic                     overflow_err;
  logic                     busy;

  modport slave (
    input  in_wr_en, in_data, in_addr, cfg_base_addr, cfg_shift, cfg_relu_en, cfg_num_words, ram_ready,
    output ram_wr_en, ram_addr, ram_wr_data, layer_done, overflow_err, busy
  );

  modport master (
    output in_wr_en, in_data, in_addr, cfg_base_addr, cfg_shift, cfg_relu_en, cfg_num_words, ram_ready,
    input  ram_wr_en, ram_addr, ram_wr_data, layer_done, overflow_err, busy
  );
endinterface

// File: rtl/ofm_requant_writer.sv
// rtl/ofm_requant_writer.sv - requantizes accumulator groups to packed int8 and streams them into the IFM RAM
module ofm_requant_writer #(
  parameter int LANES      = 4,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  ofm_requant_writer_if.slave bus
);
  localparam int WORD_W = LANES * 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = ADDR_W + WORD_W;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

  // One extra bit keeps x + rounding constant from wrapping at the top of the range.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc, input logic [4:0] shift,
                                         input logic relu);
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;
    x = {acc[ACC_W-1], acc};
    if (relu && x[ACC_W]) x = '0;
    rnd = '0;
    if (shift != 5'd0) rnd = (ACC_W+1)'(1) << (shift - 5'd1);
    y = (x + rnd) >>> shift;
    if (y > SAT_HI) return 8'h7f;
    if (y < SAT_LO) return 8'h80;
    return y[7:0];
  endfunction

  logic [WORD_W-1:0] w_word;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < LANES; i++) begin
      w_word[i*8 +: 8] = requant(bus.in_data[i*ACC_W +: ACC_W], bus.cfg_shift, bus.cfg_relu_en);
    end
  end

  assign w_addr = bus.cfg_base_addr + bus.in_addr;

  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_word;
  logic [ADDR_W-1:0] r_s1_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= bus.in_wr_en;
      if (bus.in_wr_en) begin
        r_s1_word <= w_word;
        r_s1_addr <= w_addr;
      end
    end
  end

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;
  logic              r_ram_wr_en;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [WORD_W-1:0] r_ram_data;
  logic              r_ovf;
  logic [15:0]       r_cnt;
  logic              r_done;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic [15:0]       w_cnt_nxt;
  logic [ENT_W-1:0]  w_head;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_accept  = r_ram_wr_en && bus.ram_ready;
  assign w_pop     = !w_empty && (!r_ram_wr_en || bus.ram_ready);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push    = r_s1_valid && (!w_full || w_pop);
  assign w_head    = r_mem[r_rptr[PTR_W-1:0]];
  assign w_cnt_nxt = r_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= {r_s1_addr, r_s1_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ovf       <= 1'b0;
      r_ram_wr_en <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (r_s1_valid && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_pop) begin
        r_ram_wr_en <= 1'b1;
        {r_ram_addr, r_ram_data} <= w_head;
      end else if (w_accept) begin
        r_ram_wr_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (bus.cfg_num_words != 16'd0 && w_cnt_nxt == bus.cfg_num_words) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign bus.ram_wr_en    = r_ram_wr_en;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_wr_data  = r_ram_data;
  assign bus.layer_done   = r_done;
  assign bus.overflow_err = r_ovf;
  assign bus.busy         = r_s1_valid | !w_empty | r_ram_wr_en;
endmodule

// File: tb/tb_ofm_requant_writer.sv
// tb/tb_ofm_requant_writer.sv - directed vector and sequence bench for ofm_requant_writer
module tb_ofm_requant_writer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_wr;

  ofm_requant_writer_if #(.LANES(4), .ACC_W(32), .ADDR_W(32)) bus ();

  ofm_requant_writer #(.LANES(4), .ACC_W(32), .FIFO_DEPTH(8), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [127:0] data;
    logic [4:0]   shift;
    logic         relu;
    logic [31:0]  base;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [31:0]  exp_word;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [127:0] pack4(input logic signed [31:0] l0, input logic signed [31:0] l1,
                                         input logic signed [31:0] l2, input logic signed [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] lane0, input logic [31:0] addr);
    bus.in_wr_en = 1'b1;
    bus.in_data  = pack4(lane0, 32'sd0, 32'sd0, 32'sd0);
    bus.in_addr  = addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_wr_en = 1'b0;
    bus.in_data = '0;
    bus.in_addr = '0;
    bus.cfg_base_addr = '0;
    bus.cfg_shift = '0;
    bus.cfg_relu_en = 1'b0;
    bus.cfg_num_words = '0;
    bus.ram_ready = 1'b0;

    vecs[0] = '{pack4(300, -5, 127, -200), 5'd0, 1'b0, 32'h100, 32'h2, 32'h102, 32'h807FFB7F};
    vecs[1] = '{pack4(6, -6, 5, -1000), 5'd2, 1'b1, 32'h0, 32'h4, 32'h4, 32'h00010002};
    vecs[2] = '{pack4(6, -6, 5, -1000), 5'd2, 1'b0, 32'h0, 32'h5, 32'h5, 32'h8001FF02};
    vecs[3] = '{pack4(32'sh7FFFFFFF, 32'sh80000000, 32'sh40000000, -32'sh40000001),
                5'd31, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h10, 32'hFF01FF01};
    vecs[4] = '{pack4(24, 23, -24, -25), 5'd4, 1'b0, 32'h0, 32'h7, 32'h7, 32'hFEFF0102};
    vecs[5] = '{pack4(255, 254, -3, 3), 5'd1, 1'b1, 32'h1000, 32'hFFF, 32'h1FFF, 32'h02007F7F};
    vecs[6] = '{pack4(-1, 0, 128, -128), 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h007F0000};

    tick();
    tick();
    chk("reset ram_wr_en", bus.ram_wr_en, 0);
    chk("reset ram_addr", bus.ram_addr, 0);
    chk("reset ram_wr_data", bus.ram_wr_data, 0);
    chk("reset layer_done", bus.layer_done, 0);
    chk("reset overflow_err", bus.overflow_err, 0);
    chk("reset busy", bus.busy, 0);
    rst = 1'b0;

    bus.ram_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.cfg_shift = vecs[i].shift;
      bus.cfg_relu_en = vecs[i].relu;
      bus.cfg_base_addr = vecs[i].base;
      bus.in_data = vecs[i].data;
      bus.in_addr = vecs[i].addr;
      bus.in_wr_en = 1'b1;
      tick();
      bus.in_wr_en = 1'b0;
      tick();
      chk($sformatf("vec%0d wr_en at N+2", i), bus.ram_wr_en, 0);
      tick();
      chk($sformatf("vec%0d wr_en at N+3", i), bus.ram_wr_en, 1);
      chk($sformatf("vec%0d addr", i), bus.ram_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d data", i), bus.ram_wr_data, vecs[i].exp_word);
      chk($sformatf("vec%0d layer_done", i), bus.layer_done, 0);
      tick();
      chk($sformatf("vec%0d wr_en after accept", i), bus.ram_wr_en, 0);
      chk($sformatf("vec%0d busy after accept", i), bus.busy, 0);
    end

    // Streaming with layer completion, run twice to show the counter restarts from 0.
    do_reset();
    bus.cfg_shift = 5'd0;
    bus.cfg_relu_en = 1'b0;
    bus.cfg_base_addr = 32'h200;
    bus.cfg_num_words = 16'd4;
    bus.ram_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int t = 1; t <= 9; t++) begin
        if (t <= 4) drive(32'(t - 1), 32'(t - 1));
        else bus.in_wr_en = 1'b0;
        tick();
        if (t >= 3 && t <= 6) begin
          chk($sformatf("stream%0d t%0d wr_en", rep, t), bus.ram_wr_en, 1);
          chk($sformatf("stream%0d t%0d addr", rep, t), bus.ram_addr, 32'h200 + 32'(t - 3));
          chk($sformatf("stream%0d t%0d data", rep, t), bus.ram_wr_data, 32'(t - 3));
        end else begin
          chk($sformatf("stream%0d t%0d wr_en idle", rep, t), bus.ram_wr_en, 0);
        end
        chk($sformatf("stream%0d t%0d layer_done", rep, t), bus.layer_done, (t == 7) ? 1 : 0);
      end
    end

    // Backpressure: 12 groups into a stalled RAM, 3 of them are dropped.
    do_reset();
    bus.cfg_num_words = 16'd0;
    bus.cfg_base_addr = 32'h300;
    bus.ram_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(32'(k + 1), 32'(k));
      tick();
      if (k >= 2) begin
        chk($sformatf("bp k%0d wr_en held", k), bus.ram_wr_en, 1);
        chk($sformatf("bp k%0d data held", k), bus.ram_wr_data, 32'h1);
        chk($sformatf("bp k%0d addr held", k), bus.ram_addr, 32'h300);
      end
      chk($sformatf("bp k%0d overflow_err", k), bus.overflow_err, (k >= 10) ? 1 : 0);
    end
    bus.in_wr_en = 1'b0;
    tick();
    tick();
    tick();
    chk("bp overflow_err set", bus.overflow_err, 1);
    chk("bp busy while stalled", bus.busy, 1);
    bus.ram_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("bp drain%0d wr_en", j), bus.ram_wr_en, 1);
      chk($sformatf("bp drain%0d data", j), bus.ram_wr_data, 32'(j + 1));
      chk($sformatf("bp drain%0d addr", j), bus.ram_addr, 32'h300 + 32'(j));
      tick();
    end
    chk("bp wr_en after drain", bus.ram_wr_en, 0);
    chk("bp busy after drain", bus.busy, 0);
    chk("bp overflow_err sticky", bus.overflow_err, 1);

    // Full FIFO with a push landing on the single-cycle ready pulse.
    do_reset();
    bus.cfg_base_addr = 32'h400;
    bus.ram_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(32'(k + 16), 32'(k));
      tick();
    end
    bus.in_wr_en = 1'b0;
    tick();
    tick();
    drive(32'(9 + 16), 32'(9));
    tick();
    bus.in_wr_en = 1'b0;
    bus.ram_ready = 1'b1;
    chk("pp head before pulse", bus.ram_wr_data, 32'd16);
    tick();
    bus.ram_ready = 1'b0;
    chk("pp next word loaded", bus.ram_wr_data, 32'd17);
    tick();
    tick();
    chk("pp overflow_err clear", bus.overflow_err, 0);
    bus.ram_ready = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      chk($sformatf("pp drain%0d data", j), bus.ram_wr_data, 32'(j + 16));
      chk($sformatf("pp drain%0d addr", j), bus.ram_addr, 32'h400 + 32'(j));
      tick();
    end
    chk("pp wr_en after drain", bus.ram_wr_en, 0);
    chk("pp overflow_err final", bus.overflow_err, 0);

    // Reset with five words buffered behind a held output word.
    do_reset();
    bus.cfg_base_addr = 32'h200;
    bus.ram_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(32'(k + 48), 32'(k));
      tick();
    end
    bus.in_wr_en = 1'b0;
    tick();
    tick();
    chk("mid busy before reset", bus.busy, 1);
    rst = 1'b1;
    tick();
    chk("mid ram_wr_en", bus.ram_wr_en, 0);
    chk("mid ram_addr", bus.ram_addr, 0);
    chk("mid ram_wr_data", bus.ram_wr_data, 0);
    chk("mid layer_done", bus.layer_done, 0);
    chk("mid overflow_err", bus.overflow_err, 0);
    chk("mid busy", bus.busy, 0);
    rst = 1'b0;
    bus.ram_ready = 1'b1;
    n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ram_wr_en) n_wr++;
    end
    chk("mid no stale writes", n_wr, 0);
    drive(32'h55, 32'h9);
    tick();
    bus.in_wr_en = 1'b0;
    tick();
    tick();
    chk("post reset wr_en", bus.ram_wr_en, 1);
    chk("post reset data", bus.ram_wr_data, 32'h55);
    chk("post reset addr", bus.ram_addr, 32'h209);
    n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ram_wr_en) n_wr++;
    end
    chk("post reset single write", n_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
